// File: rtl/instr_encode_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_encode_loader
// Purpose  : Encodes instruction fields into bytes and writes them to
//            instruction memory in sequential 8-bit-address sessions. An
//            op byte is {opcode,ra,rb}. L-format opcodes (1101/1110/1111)
//            add an immediate byte. Each session holds up to 256 bytes.
// Options  : LOADER_CHECKSUM_EN adds checksum[7:0], the XOR of the bytes
//            written in the session.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encode_loader (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] base_addr,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] opcode,
    input  logic [1:0] ra,
    input  logic [1:0] rb,
    input  logic [7:0] imm,
    input  logic       finish,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
`ifdef LOADER_CHECKSUM_EN
    output logic [7:0] checksum,
`endif
    output logic [8:0] wr_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READY  = 2'd1,
        S_WR_OP  = 2'd2,
        S_WR_IMM = 2'd3
    } state_t;

    state_t     r_state;
    logic [7:0] r_ptr;
    logic [8:0] r_wr_count;
    logic       r_err;
    logic       r_done;
    logic       r_we;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_imm;
    logic       r_is_l;
    logic       r_fits;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
`endif

    logic       w_is_l;
    logic [8:0] w_space;
    logic [8:0] w_len;
    logic       w_fits;
    logic [7:0] w_ptr_inc;

    // Instruction length and remaining session capacity, decided at handshake
    // so the whole instruction is either written completely or not at all.
    assign w_is_l    = (opcode >= 4'hD);
    assign w_space   = 9'd256 - r_wr_count;
    assign w_len     = w_is_l ? 9'd2 : 9'd1;
    assign w_fits    = (w_space >= w_len);
    assign w_ptr_inc = r_ptr + 8'd1;

    // Loader FSM: session control, byte sequencing and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= 8'd0;
            r_wr_count <= 9'd0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 8'd0;
            r_wdata    <= 8'd0;
            r_imm      <= 8'd0;
            r_is_l     <= 1'b0;
            r_fits     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_we <= 1'b0;
                    if (start) begin
                        r_state    <= S_READY;
                        r_ptr      <= base_addr;
                        r_wr_count <= 9'd0;
                        r_err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        r_csum     <= 8'd0;
`endif
                    end
                end
                S_READY: begin
                    if (in_valid) begin
                        // Instruction wins over a simultaneous finish.
                        r_state <= S_WR_OP;
                        r_imm   <= imm;
                        r_is_l  <= w_is_l;
                        r_fits  <= w_fits;
                        r_we    <= w_fits;
                        r_addr  <= r_ptr;
                        r_wdata <= {opcode, ra, rb};
`ifdef LOADER_CHECKSUM_EN
                        if (w_fits) begin
                            r_csum <= r_csum ^ {opcode, ra, rb};
                        end
`endif
                    end else if (finish) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                S_WR_OP: begin
                    if (r_fits) begin
                        r_ptr      <= w_ptr_inc;
                        r_wr_count <= r_wr_count + 9'd1;
                        if (r_is_l) begin
                            r_state <= S_WR_IMM;
                            r_we    <= 1'b1;
                            r_addr  <= w_ptr_inc;
                            r_wdata <= r_imm;
`ifdef LOADER_CHECKSUM_EN
                            r_csum  <= r_csum ^ r_imm;
`endif
                        end else begin
                            r_state <= S_READY;
                            r_we    <= 1'b0;
                        end
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= S_READY;
                        r_we    <= 1'b0;
                    end
                end
                S_WR_IMM: begin
                    r_ptr      <= w_ptr_inc;
                    r_wr_count <= r_wr_count + 9'd1;
                    r_we       <= 1'b0;
                    r_state    <= S_READY;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    // The strobe is masked by rst so a reset landing on a write cycle
    // suppresses that write at the same edge.
    assign mem_we    = r_we & ~rst;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign in_ready  = (r_state == S_READY);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign wr_count  = r_wr_count;
`ifdef LOADER_CHECKSUM_EN
    assign checksum  = r_csum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_encode_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encode_loader
// Purpose  : Directed self-checking bench for instr_encode_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encode_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] imm;
    logic       finish;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [8:0] wr_count;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int total = 0;
    int bad   = 0;

    instr_encode_loader u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .ra        (ra),
        .rb        (rb),
        .imm       (imm),
        .finish    (finish),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
`ifdef LOADER_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b);
        start = 1'b1; base_addr = b;
        tick();
        start = 1'b0;
    endtask

    task automatic do_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        tick();
    endtask

    task automatic send(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b, input logic [7:0] im);
        opcode = op; ra = a; rb = b; imm = im; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", mem_we); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (wr_count !== 9'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", wr_count); end
        total++; if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin bad++; $display("FAIL reset_addr_data: got %h/%h want 00/00", mem_addr, mem_wdata); end
    endtask

    task automatic test_add();
        do_start(8'h10);
        total++; if (in_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL add_ready: got %b/%b want 1/1", in_ready, busy); end
        send(4'b0001, 2'd1, 2'd2, 8'h00);
        total++; if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 8'h16) begin bad++; $display("FAIL add_write: got we=%b %h=%h want we=1 10=16", mem_we, mem_addr, mem_wdata); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL add_ready_low: got %b want 0", in_ready); end
        tick();
        total++; if (mem_we !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL add_after: got we=%b rdy=%b want 0/1", mem_we, in_ready); end
        total++; if (wr_count !== 9'd1) begin bad++; $display("FAIL add_cnt: got %0d want 1", wr_count); end
        do_finish();
    endtask

    task automatic test_loadimm();
        do_start(8'h20);
        send(4'b1111, 2'd3, 2'd0, 8'hA5);
        total++; if (mem_we !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 8'hFC) begin bad++; $display("FAIL li_op: got we=%b %h=%h want we=1 20=FC", mem_we, mem_addr, mem_wdata); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL li_ready1: got %b want 0", in_ready); end
        tick();
        total++; if (mem_we !== 1'b1 || mem_addr !== 8'h21 || mem_wdata !== 8'hA5) begin bad++; $display("FAIL li_imm: got we=%b %h=%h want we=1 21=A5", mem_we, mem_addr, mem_wdata); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL li_ready2: got %b want 0", in_ready); end
        tick();
        total++; if (mem_we !== 1'b0 || in_ready !== 1'b1 || wr_count !== 9'd2) begin bad++; $display("FAIL li_after: got we=%b rdy=%b cnt=%0d want 0/1/2", mem_we, in_ready, wr_count); end
        do_finish();
    endtask

    task automatic test_wrap();
        do_start(8'hFF);
        send(4'b1110, 2'd0, 2'd1, 8'h07);
        total++; if (mem_we !== 1'b1 || mem_addr !== 8'hFF || mem_wdata !== 8'hE1) begin bad++; $display("FAIL wrap_op: got we=%b %h=%h want we=1 FF=E1", mem_we, mem_addr, mem_wdata); end
        tick();
        total++; if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 8'h07) begin bad++; $display("FAIL wrap_imm: got we=%b %h=%h want we=1 00=07", mem_we, mem_addr, mem_wdata); end
        tick();
        total++; if (err !== 1'b0 || wr_count !== 9'd2) begin bad++; $display("FAIL wrap_err: got err=%b cnt=%0d want 0/2", err, wr_count); end
        do_finish();
    endtask

    task automatic test_capacity();
        logic [7:0] exp_addr;
        do_start(8'h00);
        for (int i = 0; i < 255; i++) begin
            exp_addr = i[7:0];
            send(4'b0000, 2'd0, 2'd0, 8'h00);
            total++; if (mem_we !== 1'b1 || mem_addr !== exp_addr) begin bad++; $display("FAIL cap_fill: got we=%b addr=%h want we=1 addr=%h", mem_we, mem_addr, exp_addr); end
            tick();
        end
        total++; if (wr_count !== 9'd255 || err !== 1'b0) begin bad++; $display("FAIL cap_255: got cnt=%0d err=%b want 255/0", wr_count, err); end
        send(4'b1101, 2'd2, 2'd3, 8'h55);
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL cap_load_we: got %b want 0", mem_we); end
        tick();
        total++; if (err !== 1'b1 || wr_count !== 9'd255 || mem_we !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL cap_load: got err=%b cnt=%0d we=%b rdy=%b want 1/255/0/1", err, wr_count, mem_we, in_ready); end
        send(4'b0000, 2'd0, 2'd0, 8'h00);
        total++; if (mem_we !== 1'b1 || mem_addr !== 8'hFF || mem_wdata !== 8'h00) begin bad++; $display("FAIL cap_nop: got we=%b %h=%h want we=1 FF=00", mem_we, mem_addr, mem_wdata); end
        tick();
        total++; if (wr_count !== 9'd256 || err !== 1'b1) begin bad++; $display("FAIL cap_256: got cnt=%0d err=%b want 256/1", wr_count, err); end
        send(4'b0010, 2'd0, 2'd0, 8'h00);
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL cap_full_we: got %b want 0", mem_we); end
        tick();
        total++; if (wr_count !== 9'd256) begin bad++; $display("FAIL cap_full_cnt: got %0d want 256", wr_count); end
        do_finish();
        do_start(8'h00);
        total++; if (err !== 1'b0 || wr_count !== 9'd0) begin bad++; $display("FAIL cap_restart: got err=%b cnt=%0d want 0/0", err, wr_count); end
        do_finish();
    endtask

    task automatic test_finish();
        do_start(8'h40);
        finish = 1'b1;
        send(4'b0001, 2'd1, 2'd2, 8'h00);
        finish = 1'b0;
        total++; if (mem_we !== 1'b1 || mem_addr !== 8'h40 || done !== 1'b0) begin bad++; $display("FAIL fin_instr: got we=%b addr=%h done=%b want 1/40/0", mem_we, mem_addr, done); end
        tick();
        total++; if (done !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL fin_ready: got done=%b rdy=%b want 0/1", done, in_ready); end
        start = 1'b1; base_addr = 8'h99;
        tick();
        start = 1'b0;
        total++; if (wr_count !== 9'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL fin_start_ign: got cnt=%0d rdy=%b want 1/1", wr_count, in_ready); end
        finish = 1'b1;
        tick();
        finish = 1'b0;
        total++; if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL fin_done: got done=%b busy=%b rdy=%b want 1/0/0", done, busy, in_ready); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL fin_pulse: got %b want 0", done); end
    endtask

    task automatic test_reset_mid();
        do_start(8'h30);
        send(4'b1111, 2'd3, 2'd0, 8'hA5);
        total++; if (mem_we !== 1'b1 || mem_addr !== 8'h30) begin bad++; $display("FAIL rmid_op: got we=%b addr=%h want 1/30", mem_we, mem_addr); end
        tick();
        rst = 1'b1;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rmid_masked: got %b want 0", mem_we); end
        tick();
        rst = 1'b0;
        total++; if (mem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rmid_ctrl: got we=%b busy=%b rdy=%b done=%b err=%b want 0", mem_we, busy, in_ready, done, err); end
        total++; if (wr_count !== 9'd0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin bad++; $display("FAIL rmid_data: got cnt=%0d %h/%h want 0 00/00", wr_count, mem_addr, mem_wdata); end
        tick();
        total++; if (mem_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_after: got we=%b busy=%b want 0/0", mem_we, busy); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_start(8'h50);
        total++; if (checksum !== 8'h00) begin bad++; $display("FAIL cs_start: got %h want 00", checksum); end
        send(4'b0001, 2'd1, 2'd2, 8'h00);
        tick();
        total++; if (checksum !== 8'h16) begin bad++; $display("FAIL cs_first: got %h want 16", checksum); end
        send(4'b1111, 2'd3, 2'd0, 8'h00);
        total++; if (checksum !== 8'hEA) begin bad++; $display("FAIL cs_second: got %h want EA", checksum); end
        tick(); tick();
        total++; if (checksum !== 8'hEA) begin bad++; $display("FAIL cs_final: got %h want EA", checksum); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (checksum !== 8'h00) begin bad++; $display("FAIL cs_reset: got %h want 00", checksum); end
    endtask
`endif

    initial begin
        rst = 1'b0; start = 1'b0; base_addr = 8'h00; in_valid = 1'b0;
        opcode = 4'h0; ra = 2'd0; rb = 2'd0; imm = 8'h00; finish = 1'b0;
        test_reset();
        test_add();
        test_loadimm();
        test_wrap();
        test_capacity();
        test_finish();
        test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
